// File: rtl/adder_n_pkg.sv
// -----------------------------------------------------------------------------
// adder_n_pkg
// Shared datapath constants for the adder leaf cell.
//   ADDER_N_DEFAULT : default operand/sum width of adder_n
//   ADDER_N_MAX     : widest operand width the cell is intended for
// -----------------------------------------------------------------------------
package adder_n_pkg;

    localparam int ADDER_N_DEFAULT = 4;
    localparam int ADDER_N_MAX     = 32;

endpackage : adder_n_pkg

// File: rtl/adder_n_full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full adder used as the ripple stage of adder_n.
//   a, b : operand bits
//   cin  : carry into this bit
//   s    : sum bit       = a ^ b ^ cin
//   cout : carry out     = majority(a, b, cin)
// -----------------------------------------------------------------------------
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder

// File: rtl/adder_n.sv
// -----------------------------------------------------------------------------
// adder_n
// Parameterised N-bit ripple-carry adder with carry in/out, plus a registered
// copy of the result for pipelined users. Two instances chain Cout -> Cin to
// form a 2N-bit adder.
//   N      : operand and sum width, 1..32 (default ADDER_N_DEFAULT)
//   Y      : combinational sum, (A + B + Cin) mod 2^N
//   Cout   : combinational carry out of bit N-1
//   A, B   : unsigned operands
//   Cin    : carry into bit 0
//   clk    : clock for the registered copy only
//   reset  : asynchronous, active-high; clears Y_q / Cout_q
//   Y_q    : Y captured on each rising clk edge
//   Cout_q : Cout captured on each rising clk edge
// -----------------------------------------------------------------------------
module adder_n
    import adder_n_pkg::*;
#(
    parameter int N = ADDER_N_DEFAULT
) (
    output logic [N-1:0] Y,
    output logic         Cout,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    input  logic         clk,
    input  logic         reset,
    output logic [N-1:0] Y_q,
    output logic         Cout_q
);

    // c[i] is the carry into bit i; c[N] is the carry out of the top bit.
    logic [N:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < N; i++) begin : g_ripple
        full_adder u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (c[i]),
            .s    (Y[i]),
            .cout (c[i+1])
        );
    end

    assign Cout = c[N];

    // Reset only touches the registered copy; the combinational sum is
    // never gated by it.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // its input from before the edge, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Y_q    <= '0;
            Cout_q <= 1'b0;
        end else begin
            Y_q    <= Y;
            Cout_q <= Cout;
        end
    end

endmodule : adder_n

// File: tb/tb_adder_n.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_adder_n
// Self-checking bench for adder_n: exhaustive 8-bit cascade of two N=4 cells,
// directed boundaries, randomized vectors against an arithmetic model, carry-in
// ripple on N=8, registered path and asynchronous reset behaviour.
// -----------------------------------------------------------------------------
module tb_adder_n;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- cascade: two N=4 cells form an 8-bit adder -------------
    logic [7:0] ca_a, ca_b;
    logic [3:0] ca_y_lo, ca_y_hi, ca_yq_lo, ca_yq_hi;
    logic       c_mid, ca_cout_hi, ca_coutq_lo, ca_coutq_hi;

    adder_n #(.N(4)) u_lo (
        .Y(ca_y_lo), .Cout(c_mid), .A(ca_a[3:0]), .B(ca_b[3:0]), .Cin(1'b0),
        .clk(clk), .reset(reset), .Y_q(ca_yq_lo), .Cout_q(ca_coutq_lo)
    );

    adder_n #(.N(4)) u_hi (
        .Y(ca_y_hi), .Cout(ca_cout_hi), .A(ca_a[7:4]), .B(ca_b[7:4]), .Cin(c_mid),
        .clk(clk), .reset(reset), .Y_q(ca_yq_hi), .Cout_q(ca_coutq_hi)
    );

    // ---------------- single N=4 cell ----------------------------------------
    logic [3:0] a4, b4, y4, yq4;
    logic       cin4, cout4, coutq4;

    adder_n #(.N(4)) u_s4 (
        .Y(y4), .Cout(cout4), .A(a4), .B(b4), .Cin(cin4),
        .clk(clk), .reset(reset), .Y_q(yq4), .Cout_q(coutq4)
    );

    // ---------------- single N=8 cell ----------------------------------------
    logic [7:0] a8, b8, y8, yq8;
    logic       cin8, cout8, coutq8;

    adder_n #(.N(8)) u_s8 (
        .Y(y8), .Cout(cout8), .A(a8), .B(b8), .Cin(cin8),
        .clk(clk), .reset(reset), .Y_q(yq8), .Cout_q(coutq8)
    );

    // Reference model: exact unsigned sum, truncated to the cell width + carry.
    function automatic logic [4:0] model4(int a, int b, int c);
        int s = a + b + c;
        return s[4:0];
    endfunction

    function automatic logic [8:0] model8(int a, int b, int c);
        int s = a + b + c;
        return s[8:0];
    endfunction

    task automatic test_reset();
        a4 = 4'h5; b4 = 4'h6; cin4 = 1'b1;
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        ca_a = 8'h00; ca_b = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if ({ca_coutq_hi, ca_yq_hi, ca_coutq_lo, ca_yq_lo, coutq4, yq4, coutq8, yq8} !== 28'h0) begin
            n_err++;
            $display("FAIL reset_regs: got %h required 0",
                     {ca_coutq_hi, ca_yq_hi, ca_coutq_lo, ca_yq_lo, coutq4, yq4, coutq8, yq8});
        end
        // Combinational path is live even while reset is held.
        n_vec++;
        if ({cout4, y4} !== 5'h0C) begin
            n_err++;
            $display("FAIL reset_comb: got %h required 0c", {cout4, y4});
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_cascade_exhaustive();
        logic [8:0] got, exp;
        for (int i = 0; i < 256; i++) begin
            for (int j = i; j < 256; j++) begin
                ca_a = 8'(i);
                ca_b = 8'(j);
                #10ps;
                got = {ca_cout_hi, ca_y_hi, ca_y_lo};
                exp = model8(i, j, 0);
                n_vec++;
                if (got !== exp) begin
                    n_err++;
                    if (n_err <= 10)
                        $display("FAIL cascade %0d+%0d: got %h required %h", i, j, got, exp);
                end
            end
        end
    endtask

    task automatic test_boundaries();
        // {A, B, Cin, required {Cout,Y}}
        logic [13:0] vecs [5];
        vecs[0] = {4'hF, 4'hF, 1'b1, 5'h1F};
        vecs[1] = {4'h0, 4'h0, 1'b0, 5'h00};
        vecs[2] = {4'hF, 4'h0, 1'b1, 5'h10};
        vecs[3] = {4'h7, 4'h8, 1'b0, 5'h0F};
        vecs[4] = {4'hF, 4'hF, 1'b0, 5'h1E};
        foreach (vecs[k]) begin
            {a4, b4, cin4} = vecs[k][13:5];
            #1;
            n_vec++;
            if ({cout4, y4} !== vecs[k][4:0]) begin
                n_err++;
                $display("FAIL boundary %0d: got %h required %h", k, {cout4, y4}, vecs[k][4:0]);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] e4;
        logic [8:0] e8;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            e4 = model4(int'(a4), int'(b4), int'(cin4));
            e8 = model8(int'(a8), int'(b8), int'(cin8));
            #1;
            n_vec++;
            if ({cout4, y4} !== e4) begin
                n_err++;
                $display("FAIL rand4_comb %0d: got %h required %h", k, {cout4, y4}, e4);
            end
            n_vec++;
            if ({cout8, y8} !== e8) begin
                n_err++;
                $display("FAIL rand8_comb %0d: got %h required %h", k, {cout8, y8}, e8);
            end
            @(posedge clk);
            #1;
            n_vec++;
            if ({coutq4, yq4, coutq8, yq8} !== {e4, e8}) begin
                n_err++;
                $display("FAIL rand_reg %0d: got %h required %h", k, {coutq4, yq4, coutq8, yq8}, {e4, e8});
            end
        end
    endtask

    task automatic test_cin_ripple();
        a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b0;
        #1;
        n_vec++;
        if ({cout8, y8} !== 9'h0FF) begin
            n_err++;
            $display("FAIL ripple_cin0: got %h required 0ff", {cout8, y8});
        end
        cin8 = 1'b1;
        #1;
        n_vec++;
        if ({cout8, y8} !== 9'h100) begin
            n_err++;
            $display("FAIL ripple_cin1: got %h required 100", {cout8, y8});
        end
    endtask

    task automatic test_registered();
        @(negedge clk);
        a4 = 4'd3; b4 = 4'd5; cin4 = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if ({coutq4, yq4} !== 5'd8) begin
            n_err++;
            $display("FAIL reg_first: got %0d required 8", {coutq4, yq4});
        end
        @(negedge clk);
        a4 = 4'd10;
        #1;
        n_vec++;
        if ({coutq4, yq4, cout4, y4} !== {5'd8, 5'd15}) begin
            n_err++;
            $display("FAIL reg_hold: got q=%0d y=%0d required q=8 y=15", {coutq4, yq4}, {cout4, y4});
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({coutq4, yq4} !== 5'd15) begin
            n_err++;
            $display("FAIL reg_update: got %0d required 15", {coutq4, yq4});
        end
    endtask

    task automatic test_async_reset();
        // Y_q holds 15 from the previous task; assert reset mid-cycle.
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if ({coutq4, yq4} !== 5'd0) begin
            n_err++;
            $display("FAIL async_clear: got %0d required 0", {coutq4, yq4});
        end
        a4 = 4'd1;
        #1;
        n_vec++;
        if ({cout4, y4} !== 5'd6) begin
            n_err++;
            $display("FAIL async_comb: got %0d required 6", {cout4, y4});
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({coutq4, yq4} !== 5'd0) begin
            n_err++;
            $display("FAIL async_held: got %0d required 0", {coutq4, yq4});
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_vec++;
        if ({coutq4, yq4} !== 5'd0) begin
            n_err++;
            $display("FAIL release_wait: got %0d required 0", {coutq4, yq4});
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({coutq4, yq4} !== 5'd6) begin
            n_err++;
            $display("FAIL release_reload: got %0d required 6", {coutq4, yq4});
        end
    endtask

    initial begin
        test_reset();
        test_cascade_exhaustive();
        test_boundaries();
        test_cin_ripple();
        test_random();
        test_registered();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_adder_n

// File: doc/adder_n.md
# adder_n

Parameterised N-bit ripple-carry adder with carry-in and carry-out. It is the basic arithmetic leaf cell of the datapath. Two instances chain through Cout→Cin to form a 2N-bit adder. The sum path is purely combinational; a registered copy of the result is also provided for pipelined users.

## Interface
- N, default 4: operand and sum width in bits; legal range 1..32.
- clk  input  1  clock for the registered result copy only.
- reset  input  1  asynchronous, active-high; clears the registered outputs.
- Y  output  N  combinational sum, (A + B + Cin) mod 2^N.
- Cout  output  1  combinational carry out of bit N-1.
- A  input  N  unsigned operand.
- B  input  N  unsigned operand.
- Cin  input  1  carry into bit 0.
- Y_q  output  N  Y registered on the rising edge of clk.
- Cout_q  output  1  Cout registered on the rising edge of clk.
- Port binding: instances connect by name. The Y, Cout, A, B, Cin subset keeps this relative order.
- One clock; reset is asynchronous and active-high.

## Operation
- {Cout, Y} = A + B + Cin, evaluated as an exact unsigned (N+1)-bit sum; no truncation before the carry.
- Ripple structure:
  - Bit i: s_i = a_i ^ b_i ^ c_i; c_(i+1) = a_i&b_i | a_i&c_i | b_i&c_i.
  - c_0 = Cin; Cout = c_N.
- No signed interpretation and no overflow flag. Signed users derive overflow externally from the operand and sum MSBs.
- Cascading: feeding the low instance's Cout into the high instance's Cin gives an exact 2N-bit sum plus final carry.
- X or Z on any input may propagate to the outputs; no masking.

## Timing
- Y and Cout: combinational, zero cycles of latency. They settle within one combinational propagation after any change to A, B or Cin, independent of clk and reset.
- Y_q and Cout_q: one-cycle latency. On each rising clk edge they capture the current Y and Cout.
- Reset:
  - While reset is high, Y_q = 0 and Cout_q = 0 immediately, without waiting for a clock edge.
  - Reset deassertion takes effect at the next clk edge.
- Reset never affects the combinational Y and Cout.
- Boundaries:
  - All-ones + all-ones + Cin=1 gives Y = all-ones, Cout = 1.
  - All-zero inputs give Y = 0, Cout = 0.
  - All-ones + 0 + Cin=1 wraps to Y = 0, Cout = 1.

## Structure
- Sub-module full_adder: 1-bit a, b, cin → s, cout. Instantiated N times in a generate loop, with an internal carry vector c[N:0].
- adder_n top: generate chain, a single always_ff for the Y_q/Cout_q registers, and the reset clause.
- No shared package is needed. The default width constant ADDER_N_DEFAULT = 4 may live in the datapath package if other blocks reference it.

## Test plan
- Exhaustive cascade: two N=4 instances; low Cin=0, low Cout → high Cin. For all i ≤ j < 256, A=i, B=j, wait 10 ps → {high Cout, Y[7:0]} == i+j. Example: 255+255 → 0x1FE.
- Single instance, N=4:
  - A=4'hF, B=4'h0, Cin=1 → Y=4'h0, Cout=1.
  - A=4'h7, B=4'h8, Cin=0 → Y=4'hF, Cout=0.
- Carry-in ripple: N=8, A=8'hFF, B=0, toggle Cin 0→1 → Y goes 8'hFF→8'h00 and Cout goes 0→1 within one propagation.
- Registered path: A=3, B=5, Cin=0 → Y_q=8 after the next clk edge. Change A to 10 between edges → Y_q holds 8 until the following edge, then shows 15.
- Asynchronous reset: assert reset mid-cycle with Y_q nonzero → Y_q=0 and Cout_q=0 immediately, while Y still tracks A+B+Cin. Deassert → Y_q reloads at the next edge.
